swap_endian_seq: RTL and testbench

//  Sequences one run of the byte-swap datapath. On run it latches a word count and a swap

---
 rtl/swap_endian_seq.sv | 69 ++++++
 tb/tb_swap_endian_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/swap_endian_seq.sv
// swap_endian_seq: runs one counted transfer of words through an optional 4-byte swap onto a registered output stream
module swap_endian_seq #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_swap,
    output logic              running,
    output logic              done,
    output logic              swap_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LEN_W-1:0]  words_left
);
    typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;
    state_t state, state_nx;
    logic [LEN_W-1:0] in_cnt;
    logic in_xfer, out_xfer, start;
    logic [DATA_W-1:0] swapped;
    assign swapped = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
    assign in_xfer = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign start = (state == IDLE) && run;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state and state-decoded outputs; FIN lasts one cycle and carries done
    always_comb begin
        state_nx = IDLE;
        running = 1'b0;
        done = 1'b0;
        in_ready = 1'b0;
        state_nx = (state == IDLE) ? (run ? ((cfg_len == '0) ? FIN : BUSY) : IDLE) :
                   (state == BUSY) ? ((out_xfer && words_left == LEN_W'(1)) ? FIN : BUSY) : IDLE;
        running = (state == BUSY) || (state == FIN);
        done = (state == FIN);
        in_ready = (state == BUSY) && (in_cnt != '0) && (!out_valid || out_ready);
    end
    // run config latch, counters and the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_en <= 1'b0;
            in_cnt <= '0;
            words_left <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else if (start) begin
            swap_en <= cfg_swap;
            in_cnt <= cfg_len;
            words_left <= cfg_len;
        end else begin
            if (in_xfer) begin
                out_data <= swap_en ? swapped : in_data;
                in_cnt <= in_cnt - LEN_W'(1);
            end
            if (out_xfer) words_left <= words_left - LEN_W'(1);
            out_valid <= in_xfer ? 1'b1 : out_xfer ? 1'b0 : out_valid;
        end
    end
endmodule

// File: tb/tb_swap_endian_seq.sv
// tb_swap_endian_seq: directed runs of the byte-swap sequencer against hand-computed words
module tb_swap_endian_seq;
    logic        clk = 1'b0;
    logic        rst, run, cfg_swap, running, done, swap_en;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] cfg_len, words_left;
    logic [31:0] in_data, out_data;
    logic [31:0] din[$];
    logic [31:0] dexp[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    swap_endian_seq dut (
        .clk(clk), .rst(rst), .run(run), .cfg_len(cfg_len), .cfg_swap(cfg_swap),
        .running(running), .done(done), .swap_en(swap_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .words_left(words_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_running"}, 32'(running), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_swap_en"}, 32'(swap_en), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_words_left"}, 32'(words_left), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    // rdy_mode 1: out_ready 1,0,0,1 repeating; gap_mode 1: in_valid low every third cycle; mid_run: re-pulse run with other config
    task automatic stream(input logic [15:0] len, input logic sw, input int rdy_mode, input int gap_mode, input int mid_run);
        int k = 0;
        int n = 0;
        int ndone = 0;
        int last_out = -1;
        int done_cyc = -1;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        run = 1'b1;
        cfg_len = len;
        cfg_swap = sw;
        @(negedge clk);
        run = 1'b0;
        #1;
        check("start_running", 32'(running), 1);
        check("start_words_left", 32'(words_left), 32'(len));
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            run = (mid_run != 0) && (c == 1);
            cfg_len = (mid_run != 0) ? 16'd9 : len;
            cfg_swap = (mid_run != 0) ? 1'b0 : sw;
            in_valid = (k >= din.size()) || gap_mode == 0 || (c % 3 != 1);
            in_data = (k < din.size()) ? din[k] : 32'hBAD0_0BAD;
            out_ready = (rdy_mode == 0) || (c % 4 == 0) || (c % 4 == 3);
            #1;
            check("swap_en_held", 32'(swap_en), 32'(sw));
            if (k >= din.size()) check("no_extra_in", 32'(in_ready), 0);
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 0);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                check($sformatf("out_word%0d", n), out_data, (n < dexp.size()) ? dexp[n] : 32'hFFFF_FFFF);
                n++;
                last_out = c;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
                check("done_running", 32'(running), 1);
                check("done_out_valid", 32'(out_valid), 0);
                check("done_words_left", 32'(words_left), 0);
                break;
            end
        end
        check("done_seen", 32'(ndone), 1);
        check("words_out", 32'(n), 32'(dexp.size()));
        check("words_in", 32'(k), 32'(din.size()));
        if (len == 0) check("empty_done_cycle", 32'(done_cyc), 0);
        else if (rdy_mode == 0 && gap_mode == 0) begin
            check("last_out_cycle", 32'(last_out), 32'(len));
            check("done_after_last", 32'(done_cyc), 32'(len) + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        run = 1'b0;
        #1;
        check("after_done", 32'(done), 0);
        check("after_running", 32'(running), 0);
        check("after_swap_en_kept", 32'(swap_en), 32'(sw));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        run = 1'b0;
        cfg_len = '0;
        cfg_swap = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        #12;
        check_idle_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        din = {32'h11223344, 32'hAABBCCDD, 32'h00000000, 32'hFFFFFFFF};
        dexp = {32'h44332211, 32'hDDCCBBAA, 32'h00000000, 32'hFFFFFFFF};
        stream(16'd4, 1'b1, 0, 0, 0);

        din = {32'h01020304, 32'h05060708, 32'h090A0B0C};
        dexp = {32'h01020304, 32'h05060708, 32'h090A0B0C};
        stream(16'd3, 1'b0, 0, 0, 0);

        din = {32'hDEADBEEF, 32'h12345678, 32'h00FF00FF, 32'hCAFEF00D};
        dexp = {32'hEFBEADDE, 32'h78563412, 32'hFF00FF00, 32'h0DF0FECA};
        stream(16'd4, 1'b1, 1, 1, 0);

        din.delete();
        dexp.delete();
        stream(16'd0, 1'b1, 0, 0, 0);

        din = {32'hA1B2C3D4, 32'h0000FFFF, 32'h80000001};
        dexp = {32'hD4C3B2A1, 32'hFFFF0000, 32'h01000080};
        stream(16'd3, 1'b1, 0, 0, 1);

        @(negedge clk);
        run = 1'b1;
        cfg_len = 16'd5;
        cfg_swap = 1'b1;
        @(negedge clk);
        run = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h01234567;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (out_valid && out_ready) n++;
        end
        check("abort_emitted", 32'(n), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outs("abort");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("abort_no_done", 32'(done), 0);

        din = {32'h13579BDF, 32'h2468ACE0};
        dexp = {32'h13579BDF, 32'h2468ACE0};
        stream(16'd2, 1'b0, 0, 0, 0);

        @(negedge clk);
        run = 1'b1;
        cfg_len = 16'hFFFF;
        cfg_swap = 1'b0;
        @(negedge clk);
        run = 1'b0;
        #1;
        check("max_words_left", 32'(words_left), 32'h0000FFFF);
        check("max_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h55AA55AA;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("max_out_word", out_data, 32'h55AA55AA);
        check("max_left_pre", 32'(words_left), 32'h0000FFFF);
        @(negedge clk);
        #1;
        check("max_left_post", 32'(words_left), 32'h0000FFFE);
        check("max_still_running", 32'(running), 1);
        rst = 1'b1;
        #1;
        check_idle_outs("max_reset");
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
